mem_ctrl_sync: RTL and testbench

Parametrised memory controller that succeeds the fixed 16x256 RAM-plus-decode glue. It sits between the CPU's mem_cmd/mem_addr bus and a synchronous RAM core. It adds:
- a programmable mapped window (BASE_ADDR, MEM_DEPTH)
- configurable read latency
- an explicit mem_ready/mem_err response handshake
- registered, never-tristated read data

Unmapped accesses and illegal commands complete with an error response instead of floating the bus.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/sync_ram_core.sv | 25 ++
 rtl/mem_ctrl_sync.sv | 122 ++++++++++++
 tb/tb_mem_ctrl_sync.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared command codes, FSM state encoding and parameter checks for mem_ctrl_sync.
package mem_ctrl_pkg;

  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;
  localparam logic [1:0] MILLEGAL = 2'b11;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_RESP  = 3'd2,
    WR_RESP  = 3'd3,
    ERR_RESP = 3'd4
  } state_t;

  // True when a read latency fits the 2-bit countdown in the controller.
  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sync_ram_core.sv
// Single-clock RAM: one write port, one registered read port.
// A read of the word being written in the same cycle returns the old data.
module sync_ram_core #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port share the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_ctrl_sync.sv
// CPU-side memory controller: decodes a mapped window onto sync_ram_core and
// answers every command with a one-cycle mem_ready (plus mem_err on misses).
module mem_ctrl_sync
  import mem_ctrl_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 9,
  parameter int    MEM_DEPTH = 256,
  parameter int    BASE_ADDR = 0,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = "data.txt"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [1:0]      CNT_INIT = 2'(RD_LAT - 1);

  generate
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
      $error("mem_ctrl_sync: RD_LAT out of range 1..4");
    end
  endgenerate

  state_t              state;
  logic [1:0]          cnt;
  logic [RAM_AW-1:0]   rd_idx;
  logic [ADDR_W:0]     local_x;
  logic [RAM_AW-1:0]   ram_idx;
  logic                hit;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_raddr;
  logic [DATA_W-1:0]   ram_rdata;

  // One extra bit on the subtraction: addresses below BASE borrow into the MSB,
  // which makes them larger than any legal depth, so one compare covers both bounds.
  assign local_x = {1'b0, mem_addr} - BASE_X;
  assign hit     = (local_x < DEPTH_X);
  assign ram_idx = local_x[RAM_AW-1:0];

  // Writes land on the accept edge; reads start on the accept edge too so the
  // RAM output is ready once the countdown expires.
  assign ram_we    = !reset && (state == IDLE) && (mem_cmd == MWRITE) && hit;
  assign ram_raddr = (state == IDLE) ? ram_idx : rd_idx;

  sync_ram_core #(
    .DATA_W   (DATA_W),
    .DEPTH    (MEM_DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_idx),
    .wdata(write_data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Request FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_idx    <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_cmd == MREAD && hit) begin
            rd_idx <= ram_idx;
            cnt    <= CNT_INIT;
            state  <= RD_WAIT;
            busy   <= 1'b1;
          end else if (mem_cmd == MWRITE && hit) begin
            state     <= WR_RESP;
            busy      <= 1'b1;
            mem_ready <= 1'b1;
          end else if (mem_cmd != MNONE) begin
            state     <= ERR_RESP;
            busy      <= 1'b1;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            read_data <= '0;
          end
        end
        RD_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            read_data <= ram_rdata;
            mem_ready <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP, WR_RESP, ERR_RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_sync.sv
// Directed bench: dut0 uses defaults, dut1 the RD_LAT=3 / BASE 0x040 / depth 100 window.
module tb_mem_ctrl_sync;

  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_ILL = 2'b11;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [1:0]  cmd [2];
  logic [8:0]  addr [2];
  logic [15:0] wdata [2];
  logic [15:0] rd [2];
  logic        rdy [2];
  logic        err [2];
  logic        bsy [2];

  logic [15:0] last_rd [2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_ctrl_sync #(.INIT_FILE("")) dut0 (
    .clk(clk), .reset(rst[0]), .mem_cmd(cmd[0]), .mem_addr(addr[0]),
    .write_data(wdata[0]), .read_data(rd[0]), .mem_ready(rdy[0]),
    .mem_err(err[0]), .busy(bsy[0])
  );

  mem_ctrl_sync #(.RD_LAT(3), .BASE_ADDR(12'h040), .MEM_DEPTH(100), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(rst[1]), .mem_cmd(cmd[1]), .mem_addr(addr[1]),
    .write_data(wdata[1]), .read_data(rd[1]), .mem_ready(rdy[1]),
    .mem_err(err[1]), .busy(bsy[1])
  );

  typedef struct {
    int          s;
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] wd;
    int          lat;
    bit          e;
    logic [15:0] exp_rd;
    string       nm;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge in an IDLE cycle, ends at the negedge of the next IDLE cycle.
  task automatic do_op(input vec_t v);
    int k;
    bit got;
    logic [15:0] exp_rd;
    chk({v.nm, "_idle_busy"}, {31'd0, bsy[v.s]}, 32'd0);
    cmd[v.s] = v.c; addr[v.s] = v.a; wdata[v.s] = v.wd;
    k = 0; got = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (rdy[v.s]) got = 1'b1;
      else chk({v.nm, "_wait_busy"}, {31'd0, bsy[v.s]}, 32'd1);
    end
    cmd[v.s] = C_NONE;
    chk({v.nm, "_lat"}, got ? k : 99, v.lat);
    if (got) begin
      if (v.e)            exp_rd = 16'h0000;
      else if (v.c == C_WR) exp_rd = last_rd[v.s];
      else                exp_rd = v.exp_rd;
      chk({v.nm, "_err"}, {31'd0, err[v.s]}, {31'd0, v.e});
      chk({v.nm, "_rdata"}, {16'd0, rd[v.s]}, {16'd0, exp_rd});
      last_rd[v.s] = exp_rd;
    end
    @(negedge clk);
    chk({v.nm, "_pulse_1cyc"}, {31'd0, rdy[v.s]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0, C_WR,  9'h005, 16'h1234, 1, 0, 16'h0000, "wr005"};
    tbl[1]  = '{0, C_RD,  9'h005, 16'h0000, 2, 0, 16'h1234, "rd005"};
    tbl[2]  = '{0, C_RD,  9'h100, 16'h0000, 1, 1, 16'h0000, "rd100_miss"};
    tbl[3]  = '{0, C_WR,  9'h0FF, 16'h5A5A, 1, 0, 16'h0000, "wr0ff"};
    tbl[4]  = '{0, C_WR,  9'h1FF, 16'hDEAD, 1, 1, 16'h0000, "wr1ff_miss"};
    tbl[5]  = '{0, C_RD,  9'h0FF, 16'h0000, 2, 0, 16'h5A5A, "rd0ff_kept"};
    tbl[6]  = '{0, C_ILL, 9'h010, 16'h0000, 1, 1, 16'h0000, "illegal"};
    tbl[7]  = '{0, C_WR,  9'h010, 16'hAAAA, 1, 0, 16'h0000, "wr010"};
    tbl[8]  = '{0, C_RD,  9'h010, 16'h0000, 2, 0, 16'hAAAA, "rd010_b2b"};
    tbl[9]  = '{0, C_WR,  9'h000, 16'h0001, 1, 0, 16'h0000, "wr000"};
    tbl[10] = '{0, C_RD,  9'h000, 16'h0000, 2, 0, 16'h0001, "rd000"};
    tbl[11] = '{1, C_WR,  9'h0A3, 16'hBEEF, 1, 0, 16'h0000, "w1_wr0a3"};
    tbl[12] = '{1, C_RD,  9'h0A3, 16'h0000, 4, 0, 16'hBEEF, "w1_rd0a3"};
    tbl[13] = '{1, C_RD,  9'h0A4, 16'h0000, 1, 1, 16'h0000, "w1_rd0a4_miss"};
    tbl[14] = '{1, C_WR,  9'h03F, 16'h0BAD, 1, 1, 16'h0000, "w1_wr03f_miss"};
    tbl[15] = '{1, C_WR,  9'h040, 16'h1111, 1, 0, 16'h0000, "w1_wr040"};
    tbl[16] = '{1, C_RD,  9'h040, 16'h0000, 4, 0, 16'h1111, "w1_rd040"};
    tbl[17] = '{1, C_RD,  9'h0A3, 16'h0000, 4, 0, 16'hBEEF, "w1_rd0a3_again"};
    tbl[18] = '{1, C_ILL, 9'h050, 16'h0000, 1, 1, 16'h0000, "w1_illegal"};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd[i] = C_NONE; addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_outs%0d", i),
          {13'd0, bsy[i], rdy[i], err[i], rd[i]}, 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) do_op(tbl[i]);

    // MNONE held: nothing may respond or go busy.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mnone_idle", {29'd0, bsy[0], rdy[0], err[0]}, 32'd0);
    end

    // Asynchronous reset while the read is in RD_WAIT.
    cmd[0] = C_RD; addr[0] = 9'h005;
    @(posedge clk);
    #1 chk("pre_rst_busy", {31'd0, bsy[0]}, 32'd1);
    #1 rst[0] = 1'b1;
    #1 chk("mid_rst_outs", {13'd0, bsy[0], rdy[0], err[0], rd[0]}, 32'd0);
    cmd[0] = C_NONE;
    @(negedge clk);
    rst[0] = 1'b0;
    last_rd[0] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_ready_after_rst", {30'd0, rdy[0], bsy[0]}, 32'd0);
    end
    do_op('{0, C_RD, 9'h005, 16'h0000, 2, 0, 16'h1234, "rd005_after_rst"});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
